// File: rtl/dds_if.sv
// -----------------------------------------------------------------------------
// dds_if -- command/data/sample bundle of the direct digital synthesiser.
//
// Signals:
//   stop             1 = pause the phase accumulator and hold out
//   control_maquina  command: 00 idle, 01 load table, 10 tune/run, 11 idle
//   dds_word         3-bit unsigned tuning word (phase increment)
//   data             table sample written while loading
//   out              synthesised sample stream (registered in the DDS)
//
// Modports:
//   master  drives commands/data, observes out (testbench / controller side)
//   slave   the DDS itself
// -----------------------------------------------------------------------------
interface dds_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  stop;
  logic [1:0]            control_maquina;
  logic [2:0]            dds_word;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] out;

  modport master (
    output stop,
    output control_maquina,
    output dds_word,
    output data,
    input  out
  );

  modport slave (
    input  stop,
    input  control_maquina,
    input  dds_word,
    input  data,
    output out
  );
endinterface : dds_if

// File: rtl/dds.sv
// -----------------------------------------------------------------------------
// dds -- direct digital synthesiser with a loadable waveform table.
//
// A waveform period of 2^ADDR_WIDTH samples is first written into the internal
// RAM (command 01), then command 10 clears the phase accumulator, latches the
// tuning word and starts stepping through the table.  out is RAM[phase]
// registered, so it trails the phase by one clock.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    dds_if.slave: stop, control_maquina, dds_word, data in; out out
//
// The RAM has one write port (table load) and one read port (run) and is not
// reset, so its contents survive a reset.
// -----------------------------------------------------------------------------
module dds #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  dds_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TUNE = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] tune_q,  tune_d;
  logic [ADDR_WIDTH-1:0] wcnt_q,  wcnt_d;
  logic                  done_q,  done_d;
  logic [DATA_WIDTH-1:0] out_q,   out_d;

  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_p0;
  logic [ADDR_WIDTH-1:0] word_ext;

  // Tuning word widened to the accumulator width (zero-extended).
  assign word_ext = ADDR_WIDTH'(bus.dds_word);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (bus.control_maquina)
      2'b01: state_d = LOAD;
      2'b10: begin
        unique case (state_q)
          IDLE, LOAD: state_d = TUNE;
          TUNE, RUN:  state_d = RUN;
          default:    state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-values
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    tune_d  = tune_q;
    wcnt_d  = wcnt_q;
    done_d  = done_q;
    out_d   = out_q;
    ram_we  = 1'b0;

    // Table loading: entering LOAD only rearms the counter; writes start on
    // the following edge so the first sampled word lands at address 0.
    if (state_q != LOAD && state_d == LOAD) begin
      wcnt_d = '0;
      done_d = 1'b0;
    end else if (state_q == LOAD && state_d == LOAD && !done_q) begin
      ram_we = 1'b1;
      wcnt_d = wcnt_q + 1'b1;
      // Last address written: counter wraps to 0 and further writes stop.
      if (&wcnt_q) begin
        done_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        out_d   = '0;
      end
      LOAD: begin
        out_d = '0;
      end
      TUNE: begin
        phase_d = '0;
        tune_d  = word_ext;
        out_d   = '0;
      end
      RUN: begin
        // The tuning register keeps tracking dds_word even while paused, so a
        // word changed during stop is used on the first cycle after release.
        tune_d = word_ext;
        if (state_d != RUN) begin
          out_d = '0;
        end else if (!bus.stop) begin
          phase_d = phase_q + tune_q;
          out_d   = rd_p0;
        end
      end
      default: begin
        out_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p0: table read at the pre-increment phase
  // ---------------------------------------------------------------------------
  assign rd_p0 = ram_q[phase_q];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[wcnt_q] <= bus.data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      tune_q  <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tune_q  <= tune_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule : dds

// File: tb/tb_dds.sv
// -----------------------------------------------------------------------------
// tb_dds -- self-checking bench for the dds block.
//
// The reference model is a copy of the table contents plus a phase pointer:
// sample n of a run is table[(n * word) mod 256], pauses repeat the last
// sample, and any non-run state yields 0.
// -----------------------------------------------------------------------------
module tb_dds;

  logic clk;
  logic reset;

  dds_if #(.DATA_WIDTH(8)) bus ();

  dds #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vectors;
  int         miscompares;
  logic [7:0] tbl [256];
  int         p;
  int         w;
  logic [7:0] last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    vectors++;
    assert (bus.out === exp)
    else begin
      miscompares++;
      $error("FAIL %s: out=%0d expected=%0d", tag, bus.out, exp);
    end
  endtask

  // mode 0: ramp k, 1: random, 2: constant 0x55, 3: 3k+1
  task automatic load_table(input int n, input int mode, input bit extra);
    bus.control_maquina = 2'b01;
    tick();
    chk("load_entry_out0", 8'd0);
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       bus.data = 8'(k);
        1:       bus.data = 8'($urandom);
        2:       bus.data = 8'h55;
        default: bus.data = 8'(3 * k + 1);
      endcase
      tbl[k] = bus.data;
      tick();
      if (k % 64 == 7) chk("load_out0", 8'd0);
    end
    if (extra) begin
      // A complete table is loaded; this word must not overwrite address 0.
      bus.data = 8'hAA;
      tick();
      chk("load_inhibit_out0", 8'd0);
    end
  endtask

  // From any state: go idle, then tune with the given word and reach RUN.
  task automatic start_run(input int word);
    bus.stop            = 1'b0;
    bus.control_maquina = 2'b00;
    tick();
    chk("idle_out0", 8'd0);
    bus.dds_word        = 3'(word);
    bus.control_maquina = 2'b10;
    tick();
    tick();
    chk("tune_out0", 8'd0);
    p = 0;
    w = word;
  endtask

  task automatic run_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, tbl[p]);
      last = tbl[p];
      p = (p + w) % 256;
    end
  endtask

  task automatic freeze(input string tag, input int cycles, input int new_word);
    bus.stop     = 1'b1;
    bus.dds_word = 3'(new_word);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk(tag, last);
    end
    bus.stop = 1'b0;
    w = new_word;
  endtask

  initial begin
    vectors             = 0;
    miscompares         = 0;
    p                   = 0;
    w                   = 0;
    last                = 8'd0;
    reset               = 1'b0;
    bus.stop            = 1'b0;
    bus.control_maquina = 2'b00;
    bus.dds_word        = 3'd0;
    bus.data            = 8'd0;

    // Reset held with arbitrary inputs.
    for (int i = 0; i < 4; i++) begin
      bus.control_maquina = 2'($urandom);
      bus.dds_word        = 3'($urandom);
      bus.stop            = 1'($urandom);
      bus.data            = 8'($urandom);
      tick();
      chk("reset_out0", 8'd0);
    end
    bus.control_maquina = 2'b00;
    bus.stop            = 1'b0;
    reset               = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_idle", 8'd0);
    end

    // Ramp table, word 1: 0..255, 0, 1.
    load_table(256, 0, 1'b1);
    bus.dds_word        = 3'd1;
    bus.control_maquina = 2'b10;
    tick();
    tick();
    chk("tune_out0", 8'd0);
    p = 0;
    w = 1;
    run_check("ramp_w1", 258);

    // Word 2 then pause, switch to word 4 and release.
    start_run(2);
    run_check("ramp_w2", 129);
    freeze("stop_hold_w2", 6, 4);
    run_check("ramp_w4", 70);

    // Word 7 across the modulo wrap (…, 245, 252, 3, 10).
    start_run(7);
    run_check("ramp_w7", 40);

    // Random table, random words, 10-cycle pauses mid-run.
    load_table(256, 1, 1'b1);
    start_run(int'($urandom_range(1, 7)));
    for (int seg = 0; seg < 4; seg++) begin
      run_check("rand_run", int'($urandom_range(20, 60)));
      freeze("rand_stop", 10, int'($urandom_range(0, 7)));
    end
    run_check("rand_resume", 30);

    // Load command while running forces out to 0; then reset mid-load.
    bus.control_maquina = 2'b01;
    tick();
    chk("run_to_load_out0", 8'd0);
    for (int k = 0; k < 100; k++) begin
      bus.data = 8'h55;
      tbl[k]   = 8'h55;
      tick();
    end
    chk("load100_out0", 8'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_out0", 8'd0);
    tick();
    bus.control_maquina = 2'b00;
    reset               = 1'b1;
    tick();
    chk("after_reset_idle", 8'd0);

    // Partial reload restarts at address 0; the rest of the RAM is retained.
    load_table(10, 3, 1'b0);
    bus.dds_word        = 3'd1;
    bus.control_maquina = 2'b10;
    tick();
    tick();
    chk("tune_out0", 8'd0);
    p = 0;
    w = 1;
    run_check("reload_w1", 256);

    // Word 0 holds a constant sample.
    start_run(0);
    run_check("word0_const", 8);

    // Idle command from RUN clears out on the next edge.
    bus.control_maquina = 2'b00;
    tick();
    chk("run_to_idle_out0", 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dds
